// File: rtl/tcam_pkg.sv
// tcam_pkg: shared FSM state encoding, TCAM entry field layout helpers and clog2
// for the TCAM lookup controller.
package tcam_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESULT} state_e;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Entry layout is {valid, mask[KW-1:0], value[KW-1:0]}.
    function automatic int valid_bit(input int kw);
        return 2 * kw;
    endfunction

    function automatic int mask_msb(input int kw);
        return 2 * kw - 1;
    endfunction

    function automatic int mask_lsb(input int kw);
        return kw;
    endfunction

    function automatic int value_msb(input int kw);
        return kw - 1;
    endfunction

endpackage

// File: rtl/tcam_entry_match.sv
// tcam_entry_match: combinational ternary match of one entry against a key;
// a mask bit of 1 means the corresponding key bit is compared.
module tcam_entry_match
    import tcam_pkg::*;
#(
    parameter int KEY_WIDTH = 32
) (
    input  logic [2*KEY_WIDTH:0]  entry_i,
    input  logic [KEY_WIDTH-1:0]  key_i,
    output logic                  match_o
);
    localparam int VB   = valid_bit(KEY_WIDTH);
    localparam int MMSB = mask_msb(KEY_WIDTH);
    localparam int MLSB = mask_lsb(KEY_WIDTH);
    localparam int VMSB = value_msb(KEY_WIDTH);

    assign match_o = entry_i[VB] && (((key_i ^ entry_i[VMSB:0]) & entry_i[MMSB:MLSB]) == '0);
endmodule

// File: rtl/tcam_lookup_ctrl.sv
// tcam_lookup_ctrl: scans a TCAM table held in two RAM channels (even/odd entries) and
// reports the lowest matching index. Define TCAM_LKUP_EARLY_EXIT_EN to stop at the first hit pair.
module tcam_lookup_ctrl
    import tcam_pkg::*;
#(
    parameter int KEY_WIDTH  = 32,
    parameter int ENTRY_NUM  = 16,
    parameter int RD_LATENCY = 1,
    localparam int AW = clog2(ENTRY_NUM),
    localparam int EW = 2 * KEY_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_valid,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 key_ready,
    output logic                 rd_en_b,
    output logic                 rd_en_c,
    output logic [AW-1:0]        rd_addr_b,
    output logic [AW-1:0]        rd_addr_c,
    output logic                 regce_b,
    output logic                 regce_c,
    input  logic [EW-1:0]        rd_data_b,
    input  logic [EW-1:0]        rd_data_c,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_hit,
    output logic [AW-1:0]        res_index
);
    state_e                state_q, state_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d;
    logic [AW-1:0]         iss_q, iss_d;
    logic [AW-1:0]         cmp_q, cmp_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic                  hit_q, hit_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [1:0]            drn_q, drn_d;
    logic                  match_b, match_c, cmp_v, scan;

    tcam_entry_match #(.KEY_WIDTH(KEY_WIDTH)) u_match_b (
        .entry_i (rd_data_b),
        .key_i   (key_q),
        .match_o (match_b)
    );

    tcam_entry_match #(.KEY_WIDTH(KEY_WIDTH)) u_match_c (
        .entry_i (rd_data_c),
        .key_i   (key_q),
        .match_o (match_c)
    );

    assign scan  = state_q == SCAN;
    // pipe_q[RD_LATENCY-1] marks the cycle the data for an issued pair is on rd_data_*
    assign cmp_v = pipe_q[RD_LATENCY-1] && (scan || state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        iss_d   = iss_q;
        cmp_d   = cmp_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        drn_d   = drn_q;
        pipe_d  = (pipe_q << 1) | RD_LATENCY'(scan);
        if (state_q == IDLE && key_valid) begin
            state_d = SCAN;
            key_d   = key;
            iss_d   = '0;
            cmp_d   = '0;
            idx_d   = '0;
            hit_d   = 1'b0;
        end
        if (scan) begin
            iss_d = iss_q + 1'b1;
            if (iss_q == AW'(ENTRY_NUM / 2 - 1)) begin
                state_d = DRAIN;
                drn_d   = '0;
            end
        end
        if (state_q == DRAIN) begin
            drn_d = drn_q + 1'b1;
            if (drn_q == 2'(RD_LATENCY - 1)) state_d = RESULT;
        end
        if (cmp_v) begin
            cmp_d = cmp_q + 1'b1;
            if (!hit_q && (match_b || match_c)) begin
                hit_d = 1'b1;
                idx_d = match_b ? (cmp_q << 1) : ((cmp_q << 1) | AW'(1));
`ifdef TCAM_LKUP_EARLY_EXIT_EN
                state_d = RESULT;
                pipe_d  = '0;
`endif
            end
        end
        if (state_q == RESULT && res_ready) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            iss_q   <= '0;
            cmp_q   <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            pipe_q  <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            iss_q   <= iss_d;
            cmp_q   <= cmp_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            pipe_q  <= pipe_d;
            drn_q   <= drn_d;
        end
    end

    assign key_ready = state_q == IDLE;
    assign rd_en_b   = scan;
    assign rd_en_c   = scan;
    assign rd_addr_b = scan ? (iss_q << 1) : '0;
    assign rd_addr_c = scan ? ((iss_q << 1) | AW'(1)) : '0;
    assign regce_b   = 1'b1;
    assign regce_c   = 1'b1;
    assign res_valid = state_q == RESULT;
    assign res_hit   = res_valid && hit_q;
    assign res_index = res_valid ? idx_q : '0;
endmodule
